// File: rtl/apb_regfile_slave.sv
// APB register-file slave: NUM_REGS x DATA_WIDTH registers with wait states, PSLVERR and abort handling.
// Define APB_PSTRB_EN to make writes honour the PSTRB byte-lane strobes.
module apb_regfile_slave #(
   parameter int ADDR_WIDTH  = 32,
   parameter int DATA_WIDTH  = 32,
   parameter int NUM_REGS    = 16,
   parameter int WAIT_STATES = 2
) (
   input  logic                    PCLK,
   input  logic                    PRESETn,
   input  logic                    PSELx,
   input  logic                    PENABLE,
   input  logic                    PWRITE,
   input  logic [ADDR_WIDTH-1:0]   PADDR,
   input  logic [DATA_WIDTH-1:0]   PWDATA,
   input  logic [DATA_WIDTH/8-1:0] PSTRB,
   output logic [DATA_WIDTH-1:0]   PRDATA,
   output logic                    PREADY,
   output logic                    PSLVERR
);

   // state    | meaning
   // S_IDLE   | no transfer in flight, waiting for a setup phase
   // S_ACCESS | transfer latched, counting wait states down to completion

   localparam int NB   = DATA_WIDTH / 8;
   localparam int OFFS = $clog2(NB);
   localparam int FIW  = ADDR_WIDTH - OFFS;
   localparam int IW   = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
   localparam int CW   = (WAIT_STATES > 0) ? $clog2(WAIT_STATES + 1) : 1;
   localparam logic [FIW-1:0] LP_NREGS = FIW'(NUM_REGS);
   localparam logic [CW-1:0]  LP_WAIT  = CW'(WAIT_STATES);

   typedef enum logic {S_IDLE, S_ACCESS} state_t;

   state_t                r_state;
   logic [CW-1:0]         r_cnt;
   logic [IW-1:0]         r_idx;
   logic                  r_write;
   logic                  r_err;
   logic [DATA_WIDTH-1:0] r_wdata;
   logic [DATA_WIDTH-1:0] r_regs [NUM_REGS];

   logic [FIW-1:0]        w_full_idx;
   logic                  w_misalign;
   logic                  w_err;
   logic                  w_ready;

   assign w_full_idx = PADDR[ADDR_WIDTH-1:OFFS];

   generate
      if (OFFS > 0) begin : g_align
         assign w_misalign = |PADDR[OFFS-1:0];
      end else begin : g_noalign
         assign w_misalign = 1'b0;
      end
   endgenerate

   assign w_err = (w_full_idx >= LP_NREGS) | w_misalign;

`ifdef APB_PSTRB_EN
   logic [NB-1:0] r_strb;
`else
   logic w_unused_strb;
   assign w_unused_strb = ^PSTRB;
`endif

   // Outputs depend only on registered state, so reset forces them low at once.
   assign w_ready = (r_state == S_ACCESS) && (r_cnt == '0);
   assign PREADY  = w_ready;
   assign PSLVERR = w_ready & r_err;
   assign PRDATA  = (w_ready && !r_write && !r_err) ? r_regs[r_idx] : '0;

   always_ff @(posedge PCLK or negedge PRESETn) begin
      if (!PRESETn) begin
         r_state <= S_IDLE;
         r_cnt   <= '0;
         r_idx   <= '0;
         r_write <= 1'b0;
         r_err   <= 1'b0;
         r_wdata <= '0;
`ifdef APB_PSTRB_EN
         r_strb  <= '0;
`endif
         for (int i = 0; i < NUM_REGS; i++) begin
            r_regs[i] <= '0;
         end
      end else begin
         case (r_state)
            S_IDLE: begin
               if (PSELx && !PENABLE) begin
                  r_idx   <= w_full_idx[IW-1:0];
                  r_write <= PWRITE;
                  r_wdata <= PWDATA;
                  r_err   <= w_err;
`ifdef APB_PSTRB_EN
                  r_strb  <= PSTRB;
`endif
                  r_cnt   <= LP_WAIT;
                  r_state <= S_ACCESS;
               end
            end
            S_ACCESS: begin
               if (!PSELx) begin
                  r_state <= S_IDLE;
               end else if (r_cnt == '0) begin
                  if (r_write && !r_err) begin
`ifdef APB_PSTRB_EN
                     for (int b = 0; b < NB; b++) begin
                        if (r_strb[b]) begin
                           r_regs[r_idx][8*b +: 8] <= r_wdata[8*b +: 8];
                        end
                     end
`else
                     r_regs[r_idx] <= r_wdata;
`endif
                  end
                  r_state <= S_IDLE;
               end else if (PENABLE) begin
                  r_cnt <= r_cnt - CW'(1);
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_apb_regfile_slave.sv
// Scoreboard bench for apb_regfile_slave: driver pushes model responses, negedge monitor compares on PREADY.
module tb_apb_regfile_slave;

   localparam int AW = 32;
   localparam int DW = 32;
   localparam int NR = 16;
   localparam int WS = 2;

   logic          clk = 1'b0;
   logic          PRESETn;
   logic          PSELx;
   logic          PENABLE;
   logic          PWRITE;
   logic [AW-1:0] PADDR;
   logic [DW-1:0] PWDATA;
   logic [3:0]    PSTRB;
   logic [DW-1:0] PRDATA;
   logic          PREADY;
   logic          PSLVERR;

   apb_regfile_slave #(
      .ADDR_WIDTH (AW),
      .DATA_WIDTH (DW),
      .NUM_REGS   (NR),
      .WAIT_STATES(WS)
   ) dut (
      .PCLK   (clk),
      .PRESETn(PRESETn),
      .PSELx  (PSELx),
      .PENABLE(PENABLE),
      .PWRITE (PWRITE),
      .PADDR  (PADDR),
      .PWDATA (PWDATA),
      .PSTRB  (PSTRB),
      .PRDATA (PRDATA),
      .PREADY (PREADY),
      .PSLVERR(PSLVERR)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] rdata;
      logic        err;
   } rsp_t;

   rsp_t        exp_q[$];
   logic [31:0] m_regs [NR];
   int          n_total = 0;
   int          n_pass  = 0;

   function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
   endfunction

   // Reference model: word-addressed array, error on out-of-range or misaligned byte address.
   function automatic rsp_t model_xfer(input bit wr, input logic [31:0] addr,
                                       input logic [31:0] data, input logic [3:0] strb);
      rsp_t        r;
      int unsigned idx;
      logic        err;
      idx = addr / 4;
      err = (addr >= 32'(NR * 4)) || (addr % 4 != 0);
      r.err   = err;
      r.rdata = '0;
      if (wr) begin
         if (!err) begin
`ifdef APB_PSTRB_EN
            for (int b = 0; b < 4; b++)
               if (strb[b]) m_regs[idx][8*b +: 8] = data[8*b +: 8];
`else
            m_regs[idx] = data;
`endif
         end
      end else if (!err) begin
         r.rdata = m_regs[idx];
      end
      return r;
   endfunction

   always @(negedge clk) begin
      if (PRESETn === 1'b1 && PREADY === 1'b1) begin
         if (exp_q.size() == 0) begin
            n_total++;
            $display("FAIL unexpected_pready: got PREADY=1 expected no transfer at %0t", $time);
         end else begin
            rsp_t r;
            r = exp_q.pop_front();
            check("prdata", PRDATA, r.rdata);
            check("pslverr", 32'(PSLVERR), 32'(r.err));
         end
      end
   end

   task automatic idle(input int n);
      PSELx   = 1'b0;
      PENABLE = 1'b0;
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Starts at #1 after a rising edge; ends #1 after the completion edge with PSELx still high.
   task automatic xfer(input bit wr, input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb);
      int waits = 0;
      bit done  = 0;
      PSELx   = 1'b1;
      PENABLE = 1'b0;
      PWRITE  = wr;
      PADDR   = addr;
      PWDATA  = data;
      PSTRB   = strb;
      exp_q.push_back(model_xfer(wr, addr, data, strb));
      @(posedge clk);
      #1;
      PENABLE = 1'b1;
      PADDR   = $urandom;
      PWDATA  = $urandom;
      for (int c = 0; c < 50; c++) begin
         @(negedge clk);
         if (PREADY === 1'b1) begin
            done = 1;
            break;
         end
         waits++;
         @(posedge clk);
         #1;
      end
      if (!done) begin
         n_total++;
         $display("FAIL pready_timeout: got no PREADY expected PREADY after %0d waits", WS);
      end else begin
         check("wait_states", 32'(waits), 32'(WS));
      end
      @(posedge clk);
      #1;
   endtask

   task automatic read_all();
      for (int i = 0; i < NR; i++) xfer(1'b0, 32'(i * 4), 32'h0, 4'h0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got no finish expected finish by 200000");
      $fatal(1);
   end

   initial begin
      for (int i = 0; i < NR; i++) m_regs[i] = '0;
      PRESETn = 1'b0;
      PSELx   = 1'b0;
      PENABLE = 1'b0;
      PWRITE  = 1'b0;
      PADDR   = '0;
      PWDATA  = '0;
      PSTRB   = '0;
      repeat (3) @(posedge clk);
      #1;
      check("reset_pready", 32'(PREADY), 32'h0);
      check("reset_pslverr", 32'(PSLVERR), 32'h0);
      check("reset_prdata", PRDATA, 32'h0);
      PRESETn = 1'b1;
      idle(1);

      xfer(1'b0, 32'h8, 32'h0, 4'h0);
      idle(1);

      xfer(1'b1, 32'h4, 32'h0000_03E7, 4'hF);
      xfer(1'b0, 32'h4, 32'h0, 4'h0);
      idle(1);

      xfer(1'b1, 32'h40, 32'hDEAD_BEEF, 4'hF);
      xfer(1'b1, 32'h6, 32'hDEAD_BEEF, 4'hF);
      read_all();
      idle(1);

      xfer(1'b1, 32'hC, 32'h1122_3344, 4'hF);
      xfer(1'b1, 32'hC, 32'hAABB_CCDD, 4'b0101);
      xfer(1'b0, 32'hC, 32'h0, 4'h0);
      idle(1);

      // PENABLE without a setup phase must not start a transfer.
      PSELx   = 1'b1;
      PENABLE = 1'b1;
      PWRITE  = 1'b1;
      PADDR   = 32'h10;
      PWDATA  = 32'hFFFF_FFFF;
      PSTRB   = 4'hF;
      repeat (5) begin
         @(negedge clk);
         check("no_setup_pready", 32'(PREADY), 32'h0);
      end
      @(posedge clk);
      #1;
      idle(1);
      xfer(1'b0, 32'h10, 32'h0, 4'h0);
      idle(1);

      // Abort a write of 0x55 to 0xC in its second wait cycle.
      PSELx   = 1'b1;
      PENABLE = 1'b0;
      PWRITE  = 1'b1;
      PADDR   = 32'hC;
      PWDATA  = 32'h55;
      PSTRB   = 4'hF;
      @(posedge clk);
      #1;
      PENABLE = 1'b1;
      @(negedge clk);
      check("abort_wait1_pready", 32'(PREADY), 32'h0);
      @(posedge clk);
      #1;
      PSELx   = 1'b0;
      PENABLE = 1'b0;
      @(negedge clk);
      check("abort_wait2_pready", 32'(PREADY), 32'h0);
      repeat (3) begin
         @(negedge clk);
         check("abort_after_pready", 32'(PREADY), 32'h0);
      end
      @(posedge clk);
      #1;
      xfer(1'b0, 32'hC, 32'h0, 4'h0);
      idle(1);

      for (int n = 0; n < 300; n++) begin
         bit          wr;
         logic [31:0] addr;
         int          sel;
         wr  = $urandom_range(0, 1) == 1;
         sel = $urandom_range(0, 9);
         if (sel < 8)       addr = 32'($urandom_range(0, NR - 1) * 4);
         else if (sel == 8) addr = 32'($urandom_range(0, NR + 7) * 4);
         else               addr = 32'($urandom_range(0, NR * 4 + 7));
         xfer(wr, addr, $urandom, 4'($urandom_range(0, 15)));
         if ($urandom_range(0, 2) == 0) idle($urandom_range(0, 2));
      end
      idle(1);
      read_all();
      idle(1);

      // Reset while the completing ACCESS cycle of a write is on the bus.
      PSELx   = 1'b1;
      PENABLE = 1'b0;
      PWRITE  = 1'b1;
      PADDR   = 32'h44;
      PWDATA  = 32'h1234_5678;
      PSTRB   = 4'hF;
      @(posedge clk);
      #1;
      PENABLE = 1'b1;
      repeat (WS) @(posedge clk);
      #1;
      check("pre_reset_pready", 32'(PREADY), 32'h1);
      check("pre_reset_pslverr", 32'(PSLVERR), 32'h1);
      PRESETn = 1'b0;
      #1;
      check("midreset_pready", 32'(PREADY), 32'h0);
      check("midreset_pslverr", 32'(PSLVERR), 32'h0);
      check("midreset_prdata", PRDATA, 32'h0);
      PSELx   = 1'b0;
      PENABLE = 1'b0;
      @(posedge clk);
      #1;
      PRESETn = 1'b1;
      for (int i = 0; i < NR; i++) m_regs[i] = '0;
      idle(1);
      read_all();
      idle(3);

      check("queue_drained", 32'(exp_q.size()), 32'h0);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
